// File: rtl/rx_pkg.sv
// Shared definitions for the receive word framer: FSM encoding and default
// frame constants.
package rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  localparam logic [7:0] DEF_SYNC_WORD  = 8'hBC;
  localparam int         DEF_FRAME_LEN  = 4;
  localparam int         BITS_PER_CYCLE = 3;

endpackage

// File: rtl/rx_word_framer_if.sv
// Bit-in / word-out bundle of the framer. The master side feeds recovered
// bits and receives words; the slave side is the framer itself.
interface rx_word_framer_if #(
  parameter int WORD_W = 8
);

  logic [2:0]        bits_in;
  logic [1:0]        bits_cnt;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              frame_start;
  logic              locked;

  modport master (
    output bits_in, bits_cnt,
    input  word_out, word_valid, frame_start, locked
  );

  modport slave (
    input  bits_in, bits_cnt,
    output word_out, word_valid, frame_start, locked
  );

endinterface

// File: rtl/rx_bit_shifter.sv
// Shifts up to three new bits into the sliding window and flags, for each
// bit position, whether the window after that bit equals the sync pattern.
module rx_bit_shifter
  import rx_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(DEF_SYNC_WORD)
) (
  input  logic [WORD_W-1:0]      window,
  input  logic [2:0]             bits_in,
  output logic [2:0][WORD_W-1:0] win,
  output logic [2:0]             match
);

  logic [WORD_W-1:0] win0_s;
  logic [WORD_W-1:0] win1_s;
  logic [WORD_W-1:0] win2_s;

  assign win0_s = {window[WORD_W-2:0], bits_in[0]};
  assign win1_s = {win0_s[WORD_W-2:0], bits_in[1]};
  assign win2_s = {win1_s[WORD_W-2:0], bits_in[2]};

  assign win   = {win2_s, win1_s, win0_s};
  assign match = {(win2_s == SYNC_WORD), (win1_s == SYNC_WORD), (win0_s == SYNC_WORD)};

endmodule

// File: rtl/rx_word_framer.sv
// Frame synchroniser: hunts for the sync word in a 0..3 bit/cycle stream,
// verifies it over consecutive frames, then emits payload words while locked.
module rx_word_framer
  import rx_pkg::*;
#(
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD  = WORD_W'(DEF_SYNC_WORD),
  parameter int                FRAME_LEN  = DEF_FRAME_LEN,
  parameter int                VERIFY_CNT = 2,
  parameter int                MISS_MAX   = 2
) (
  input logic             clk,
  input logic             reset,
  rx_word_framer_if.slave bus
);

  localparam int CNT_W  = $clog2(WORD_W);
  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int HIT_W  = (VERIFY_CNT > 1) ? $clog2(VERIFY_CNT + 1) : 1;
  localparam int MISS_W = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_FIRST = (FRAME_LEN > 1) ? IDX_W'(1) : IDX_W'(0);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(VERIFY_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

  // A word must span more than one cycle's worth of bits so that at most one completes per cycle.
  if (WORD_W < 4) begin : g_word_w_check
    $error("rx_word_framer: WORD_W must be at least 4");
  end

  rx_state_e         state_r;
  logic [WORD_W-1:0] window_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [HIT_W-1:0]  hit_r;
  logic [MISS_W-1:0] miss_r;
  logic [WORD_W-1:0] word_out_r;
  logic              word_valid_r;
  logic              frame_start_r;
  logic              locked_r;

  logic [2:0][WORD_W-1:0] win_s;
  logic [2:0]             match_s;

  rx_state_e         state_s;
  logic [WORD_W-1:0] window_s;
  logic [CNT_W-1:0]  cnt_s;
  logic [IDX_W-1:0]  idx_s;
  logic [HIT_W-1:0]  hit_s;
  logic [MISS_W-1:0] miss_s;
  logic [WORD_W-1:0] cap_s;
  logic              emit_s;
  logic              first_s;

  rx_bit_shifter #(
    .WORD_W    (WORD_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_shifter (
    .window  (window_r),
    .bits_in (bus.bits_in),
    .win     (win_s),
    .match   (match_s)
  );

  // Window after the last bit actually consumed this cycle.
  always_comb begin
    window_s = window_r;
    case (bus.bits_cnt)
      2'd0:    window_s = window_r;
      2'd1:    window_s = win_s[0];
      2'd2:    window_s = win_s[1];
      2'd3:    window_s = win_s[2];
      default: window_s = window_r;
    endcase
  end

  // Walk the consumed bits in arrival order, advancing the framing state per bit.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    hit_s   = hit_r;
    miss_s  = miss_r;
    cap_s   = word_out_r;
    emit_s  = 1'b0;
    first_s = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (2'(i) < bus.bits_cnt) begin
        case (state_s)
          ST_HUNT: begin
            if (match_s[i]) begin
              cnt_s   = '0;
              idx_s   = IDX_FIRST;
              hit_s   = HIT_W'(1);
              miss_s  = '0;
              state_s = (VERIFY_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
            end else begin
              state_s = ST_HUNT;
            end
          end
          ST_VERIFY, ST_LOCKED: begin
            if (cnt_s == CNT_LAST) begin
              cnt_s = '0;
              if (idx_s == '0) begin
                if (match_s[i]) begin
                  if (state_s == ST_VERIFY) begin
                    if (hit_s == HIT_LAST) begin
                      state_s = ST_LOCKED;
                      miss_s  = '0;
                    end else begin
                      hit_s = hit_s + HIT_W'(1);
                    end
                  end else begin
                    miss_s = '0;
                  end
                end else if (state_s == ST_VERIFY || miss_s == MISS_LAST) begin
                  state_s = ST_HUNT;
                  hit_s   = '0;
                  miss_s  = '0;
                end else begin
                  miss_s = miss_s + MISS_W'(1);
                end
              end else if (state_s == ST_LOCKED) begin
                emit_s  = 1'b1;
                cap_s   = win_s[i];
                first_s = (idx_s == IDX_FIRST);
              end else begin
                emit_s = 1'b0;
              end
              idx_s = (idx_s == IDX_LAST) ? IDX_W'(0) : idx_s + IDX_W'(1);
            end else begin
              cnt_s = cnt_s + CNT_W'(1);
            end
          end
          default: begin
            state_s = ST_HUNT;
          end
        endcase
      end else begin
        emit_s = emit_s;
      end
    end
  end

  // State and registered outputs; reset discards the bits presented in its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_HUNT;
      window_r      <= '0;
      cnt_r         <= '0;
      idx_r         <= '0;
      hit_r         <= '0;
      miss_r        <= '0;
      word_out_r    <= '0;
      word_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      window_r      <= window_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      hit_r         <= hit_s;
      miss_r        <= miss_s;
      word_valid_r  <= emit_s;
      frame_start_r <= emit_s & first_s;
      locked_r      <= (state_s == ST_LOCKED);
      if (emit_s) begin
        word_out_r <= cap_s;
      end
    end
  end

  assign bus.word_out    = word_out_r;
  assign bus.word_valid  = word_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.locked      = locked_r;

endmodule

// File: tb/tb_rx_word_framer.sv
// Directed bench for rx_word_framer: lock-up, variable bit rates, mid-cycle
// sync alignment, sync corruption / relock and mid-word reset.
module tb_rx_word_framer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rx_word_framer_if #(.WORD_W(8)) bus ();

  rx_word_framer #(
    .WORD_W     (8),
    .SYNC_WORD  (8'hBC),
    .FRAME_LEN  (4),
    .VERIFY_CNT (2),
    .MISS_MAX   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       bitq[$];
  logic [7:0] got_w[$];
  logic       got_fs[$];
  logic [7:0] exp_w[$];
  logic       exp_fs[$];

  // Record every strobed word together with its frame_start flag.
  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) begin
      got_w.push_back(bus.word_out);
      got_fs.push_back(bus.frame_start);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) bitq.push_back(b[i]);
  endtask

  task automatic push_frame(input logic [7:0] s, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
    push_bits(s, 8);
    push_bits(a, 8);
    push_bits(b, 8);
    push_bits(c, 8);
  endtask

  task automatic expect_word(input logic [7:0] w, input logic fs);
    exp_w.push_back(w);
    exp_fs.push_back(fs);
  endtask

  // mode 0: random 0..3 bits per cycle; otherwise a fixed count per cycle.
  task automatic feed(input int mode);
    int n;
    logic [2:0] b;
    while (bitq.size() > 0) begin
      n = (mode == 0) ? int'($urandom_range(3, 0)) : mode;
      if (n > bitq.size()) n = bitq.size();
      b = 3'($urandom);
      for (int k = 0; k < n; k++) b[k] = bitq.pop_front();
      @(negedge clk);
      bus.bits_in  = b;
      bus.bits_cnt = 2'(n);
    end
    @(negedge clk);
    bus.bits_cnt = 2'd0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.bits_in  = 3'b111;
    bus.bits_cnt = 2'd3;
    @(negedge clk);
    reset        = 1'b0;
    bus.bits_cnt = 2'd0;
    #1;
  endtask

  task automatic clear_lists();
    got_w.delete();
    got_fs.delete();
    exp_w.delete();
    exp_fs.delete();
  endtask

  task automatic chk_stream(input string tag);
    logic [7:0] g;
    logic       f;
    chk({tag, "_count"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      g = (i < got_w.size()) ? got_w[i] : 8'hxx;
      f = (i < got_fs.size()) ? got_fs[i] : 1'bx;
      chk($sformatf("%s_word%0d", tag, i), 32'(g), 32'(exp_w[i]));
      chk($sformatf("%s_fs%0d", tag, i), 32'(f), 32'(exp_fs[i]));
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.bits_in  = 3'b000;
    bus.bits_cnt = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_word_out", 32'(bus.word_out), 32'h00);
    chk("rst_word_valid", 32'(bus.word_valid), 32'h0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);

    // 1 bit per cycle: first frame verifies, second sync locks.
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    feed(1);
    chk("t1_verify_unlocked", 32'(bus.locked), 32'h0);
    chk("t1_verify_no_words", 32'(got_w.size()), 32'd0);
    push_bits(8'hBC, 8);
    feed(1);
    chk("t1_locked_after_sync2", 32'(bus.locked), 32'h1);
    push_bits(8'h11, 7);
    feed(1);
    chk("t1_no_early_strobe", 32'(bus.word_valid), 32'h0);
    bitq.push_back(1'b1);
    feed(1);
    chk("t1_strobe", 32'(bus.word_valid), 32'h1);
    chk("t1_word", 32'(bus.word_out), 32'h11);
    chk("t1_frame_start", 32'(bus.frame_start), 32'h1);
    @(negedge clk);
    #1;
    chk("t1_strobe_drop", 32'(bus.word_valid), 32'h0);
    chk("t1_word_hold", 32'(bus.word_out), 32'h11);
    chk("t1_fs_drop", 32'(bus.frame_start), 32'h0);
    push_bits(8'h22, 8);
    push_bits(8'h33, 8);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    feed(1);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    chk_stream("t1");

    // Same stream, random 0..3 bits per cycle.
    do_reset();
    clear_lists();
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    feed(0);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    chk_stream("t2");
    chk("t2_locked", 32'(bus.locked), 32'h1);

    // 5 junk bits, 3 bits/cycle: last sync bit lands at bits_in[0].
    do_reset();
    clear_lists();
    push_bits(8'hF8, 5);
    push_frame(8'hBC, 8'hA5, 8'h22, 8'h33);
    push_frame(8'hBC, 8'hA5, 8'h22, 8'h33);
    feed(3);
    expect_word(8'hA5, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    chk_stream("t3");
    chk("t3_locked", 32'(bus.locked), 32'h1);

    // Sync corruption: one miss tolerated, two consecutive drop lock.
    do_reset();
    clear_lists();
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBD, 8'h44, 8'h55, 8'h66);
    feed(1);
    chk("t4_one_miss_locked", 32'(bus.locked), 32'h1);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBD, 8'h44, 8'h55, 8'h66);
    push_bits(8'hBD, 8);
    feed(1);
    chk("t4_two_miss_unlocked", 32'(bus.locked), 32'h0);
    push_bits(8'h11, 8);
    push_bits(8'h22, 8);
    push_bits(8'h33, 8);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    feed(1);
    chk("t4_hunt_verify_no_words", 32'(got_w.size()), 32'd12);
    chk("t4_verify_unlocked", 32'(bus.locked), 32'h0);
    push_bits(8'hBC, 8);
    feed(1);
    chk("t4_relocked", 32'(bus.locked), 32'h1);
    push_bits(8'h11, 8);
    push_bits(8'h22, 8);
    push_bits(8'h33, 8);
    feed(1);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    expect_word(8'h44, 1'b1); expect_word(8'h55, 1'b0); expect_word(8'h66, 1'b0);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    expect_word(8'h44, 1'b1); expect_word(8'h55, 1'b0); expect_word(8'h66, 1'b0);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    chk_stream("t4");

    // Reset in the middle of a payload word.
    do_reset();
    clear_lists();
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_bits(8'hBC, 8);
    push_bits(8'h11, 4);
    feed(1);
    chk("t5_locked_before_reset", 32'(bus.locked), 32'h1);
    chk("t5_words_before_reset", 32'(got_w.size()), 32'd3);
    do_reset();
    chk("t5_rst_word_out", 32'(bus.word_out), 32'h00);
    chk("t5_rst_word_valid", 32'(bus.word_valid), 32'h0);
    chk("t5_rst_frame_start", 32'(bus.frame_start), 32'h0);
    chk("t5_rst_locked", 32'(bus.locked), 32'h0);
    push_bits(8'h10, 4);
    push_bits(8'h22, 8);
    push_bits(8'h33, 8);
    feed(1);
    chk("t5_no_partial_word", 32'(got_w.size()), 32'd3);
    chk("t5_hunting", 32'(bus.locked), 32'h0);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hBC, 8'h11, 8'h22, 8'h33);
    feed(1);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    expect_word(8'h11, 1'b1); expect_word(8'h22, 1'b0); expect_word(8'h33, 1'b0);
    chk_stream("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
